// File: rtl/sd_dispatcher_if.sv
// Bundle of the operand-queue, datapath-load and control-unit handshake signals of sd_dispatcher.
// The master side belongs to the producer/control unit; the slave side belongs to the dispatcher.
interface sd_dispatcher_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_c;
  logic         ld_en;
  logic [N-1:0] ld_a;
  logic [N-1:0] ld_b;
  logic [N-1:0] ld_c;
  logic         xs;
  logic         fin;
  logic         busy;
  logic [7:0]   jobs_done;
  logic         err;

  modport master (
    output in_valid, in_a, in_b, in_c, fin,
    input  in_ready, ld_en, ld_a, ld_b, ld_c, xs, busy, jobs_done, err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, fin,
    output in_ready, ld_en, ld_a, ld_b, ld_c, xs, busy, jobs_done, err
  );
endinterface

// File: rtl/sd_dispatcher.sv
// Queues operand triples and issues them one at a time: load the datapath, pulse xs, wait for fin.
// Optional WAIT watchdog enabled by defining SD_DISPATCH_TIMEOUT_EN.
module sd_dispatcher #(
  parameter int N       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           reset,
  sd_dispatcher_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;

  state_t state_q, state_d;

  logic [3*N-1:0] mem_q [DEPTH];
  logic [3*N-1:0] mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           in_ready;
  logic           push;
  logic           pop;
  logic [3*N-1:0] head;

  logic           ld_en_q, ld_en_d;
  logic [N-1:0]   ld_a_q, ld_a_d;
  logic [N-1:0]   ld_b_q, ld_b_d;
  logic [N-1:0]   ld_c_q, ld_c_d;
  logic           xs_q, xs_d;
  logic [7:0]     jobs_q, jobs_d;

`ifdef SD_DISPATCH_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0]  wd_q, wd_d;
  logic           err_q, err_d;
  logic           timeout_hit;
`endif

  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = bus.in_valid && in_ready;
  assign pop      = (state_q == LOAD);
  assign head     = mem_q[rd_ptr_q];

  // Operand FIFO; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_a, bus.in_b, bus.in_c};
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
`ifdef SD_DISPATCH_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      IDLE:  if (count_q != '0) state_d = LOAD;
      LOAD:  state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        if (bus.fin) begin
          state_d = DONE;
        end
`ifdef SD_DISPATCH_TIMEOUT_EN
        else if (wd_q == WW'(TIMEOUT - 1)) begin
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered, so ld_en/ld_* appear on the edge that pops the head and xs follows one cycle later.
  always_comb begin
    ld_en_d = (state_q == LOAD);
    ld_a_d  = ld_a_q;
    ld_b_d  = ld_b_q;
    ld_c_d  = ld_c_q;
    if (state_q == LOAD) begin
      ld_a_d = head[3*N-1:2*N];
      ld_b_d = head[2*N-1:N];
      ld_c_d = head[N-1:0];
    end
    xs_d   = (state_q == START);
    jobs_d = jobs_q + {7'd0, (state_q == DONE)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      ld_en_q  <= 1'b0;
      ld_a_q   <= '0;
      ld_b_q   <= '0;
      ld_c_q   <= '0;
      xs_q     <= 1'b0;
      jobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
      ld_en_q  <= ld_en_d;
      ld_a_q   <= ld_a_d;
      ld_b_q   <= ld_b_d;
      ld_c_q   <= ld_c_d;
      xs_q     <= xs_d;
      jobs_q   <= jobs_d;
    end
  end

`ifdef SD_DISPATCH_TIMEOUT_EN
  // Watchdog restarts on every entry to WAIT; err stays set until reset.
  always_comb begin
    wd_d = wd_q;
    if (state_q == START) begin
      wd_d = '0;
    end else if (state_q == WAIT) begin
      wd_d = wd_q + WW'(1);
    end
    err_d = err_q | timeout_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.ld_en     = ld_en_q;
  assign bus.ld_a      = ld_a_q;
  assign bus.ld_b      = ld_b_q;
  assign bus.ld_c      = ld_c_q;
  assign bus.xs        = xs_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.jobs_done = jobs_q;
endmodule
